// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target
// among NUM_REQ requesters, one transaction at a time.
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0]         req_wdata_i,
  input  logic [NUM_REQ*4-1:0]          req_wstrb_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          rsp_error_o,
  output logic                          reg_valid_o,
  output logic                          reg_write_o,
  output logic [ADDR_WIDTH-1:0]         reg_addr_o,
  output logic [31:0]                   reg_wdata_o,
  output logic [3:0]                    reg_wstrb_o,
  input  logic                          reg_ready_i,
  input  logic [31:0]                   reg_rdata_i,
  input  logic                          reg_error_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   PTR_MOD  = (PW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           grant;
  logic [PW-1:0]           pick;
  logic [PW-1:0]           pick_off;
  logic [PW:0]             pick_sum;
  logic [2*NUM_REQ-1:0]    valid_dbl;
  logic [2*NUM_REQ-1:0]    valid_rot;
  logic                    any_req;
  logic [CW-1:0]           cnt;
  logic                    expire;

  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_wstrb;
  logic [31:0]             cap_rdata;
  logic                    cap_error;

  assign valid_dbl = {req_valid_i, req_valid_i};
  assign valid_rot = valid_dbl >> rr_ptr;
  assign any_req   = |req_valid_i;
  assign expire    = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Find first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    pick_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        pick_off = PW'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= PTR_MOD) begin
      pick_sum = pick_sum - PTR_MOD;
    end
    pick = pick_sum[PW-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (reg_ready_i || expire) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant, payload latch, wait counter, response capture, pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr    <= '0;
      grant     <= '0;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      cap_rdata <= '0;
      cap_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            cnt       <= '0;
            lat_write <= req_write_i[pick];
            lat_addr  <= req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata_i[int'(pick)*32 +: 32];
            lat_wstrb <= req_wstrb_i[int'(pick)*4 +: 4];
          end
        end
        BUSY: begin
          if (reg_ready_i) begin
            cap_rdata <= reg_rdata_i;
            cap_error <= reg_error_i;
          end else if (expire) begin
            cap_rdata <= '0;
            cap_error <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          rr_ptr <= (grant == PTR_LAST) ? '0 : grant + PW'(1);
        end
        default: begin
          rr_ptr <= rr_ptr;
        end
      endcase
    end
  end

  // Outputs decoded from state; everything idles at zero.
  always_comb begin
    req_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;
    unique case (state)
      BUSY: begin
        reg_valid_o = 1'b1;
        reg_write_o = lat_write;
        reg_addr_o  = lat_addr;
        reg_wdata_o = lat_wdata;
        reg_wstrb_o = lat_wstrb;
      end
      RESP: begin
        req_ready_o = NUM_REQ'(1) << grant;
        rsp_rdata_o = cap_rdata;
        rsp_error_o = cap_error;
      end
      default: begin
        req_ready_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: transaction-level model
// compared every cycle, plus directed literal checks.
module tb_reg_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 64;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    valid;
  logic [N-1:0]    write;
  logic [AW-1:0]   addr  [N];
  logic [31:0]     wdata [N];
  logic [3:0]      wstrb [N];
  logic [N*AW-1:0] addr_flat;
  logic [N*32-1:0] wdata_flat;
  logic [N*4-1:0]  wstrb_flat;
  logic            reg_ready;
  logic [31:0]     reg_rdata;
  logic            reg_error;

  logic [N-1:0]    req_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_error;
  logic            reg_valid;
  logic            reg_write;
  logic [AW-1:0]   reg_addr;
  logic [31:0]     reg_wdata;
  logic [3:0]      reg_wstrb;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  assign addr_flat  = {addr[2], addr[1], addr[0]};
  assign wdata_flat = {wdata[2], wdata[1], wdata[0]};
  assign wstrb_flat = {wstrb[2], wstrb[1], wstrb[0]};

  reg_bus_arbiter #(
    .NUM_REQ(N),
    .ADDR_WIDTH(AW),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(valid),
    .req_write_i(write),
    .req_addr_i(addr_flat),
    .req_wdata_i(wdata_flat),
    .req_wstrb_i(wstrb_flat),
    .req_ready_o(req_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .reg_valid_o(reg_valid),
    .reg_write_o(reg_write),
    .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_wstrb_o(reg_wstrb),
    .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one in-flight transfer,
  // a pending response pulse, and the next search start.
  bit          m_busy;
  bit          m_resp;
  int          m_grant;
  int          m_next;
  int          m_age;
  logic        m_write;
  logic [63:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_err;

  always @(posedge clk) begin
    int j;
    if (rst) begin
      m_busy = 0;
      m_resp = 0;
      m_next = 0;
      m_age  = 0;
    end else if (m_resp) begin
      m_resp = 0;
      m_next = (m_grant + 1) % N;
    end else if (m_busy) begin
      if (reg_ready) begin
        m_rdata = reg_rdata;
        m_err   = reg_error;
        m_busy  = 0;
        m_resp  = 1;
      end else if (m_age == TMO - 1) begin
        m_rdata = 32'h0;
        m_err   = 1'b1;
        m_busy  = 0;
        m_resp  = 1;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_next + k) % N;
        if (valid[j] && !m_busy) begin
          m_busy  = 1;
          m_age   = 0;
          m_grant = j;
          m_write = write[j];
          m_addr  = addr[j];
          m_wdata = wdata[j];
          m_wstrb = wstrb[j];
        end
      end
    end
  end

  logic [N-1:0] e_ready;
  logic [31:0]  e_rdata;
  logic         e_err;

  always_comb begin
    e_ready = '0;
    e_rdata = '0;
    e_err   = 1'b0;
    if (m_resp) begin
      e_ready = N'(1) << m_grant;
      e_rdata = m_rdata;
      e_err   = m_err;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_reg_valid", reg_valid, m_busy);
      chk("m_req_ready", req_ready, e_ready);
      chk("m_rsp_rdata", rsp_rdata, e_rdata);
      chk("m_rsp_error", rsp_error, e_err);
      chk("m_onehot", ($countones(req_ready) <= 1), 1);
      if (m_busy) begin
        chk("m_reg_write", reg_write, m_write);
        chk("m_reg_addr", reg_addr, m_addr);
        chk("m_reg_wdata", reg_wdata, m_wdata);
        chk("m_reg_wstrb", reg_wstrb, m_wstrb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!reg_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_valid_bound", reg_valid, 1);
  endtask

  logic [2:0] ct_exp [4];
  int tn;

  initial begin
    ct_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
    rst = 1'b1;
    valid = '0;
    write = '0;
    for (int i = 0; i < N; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
      wstrb[i] = '0;
    end
    reg_ready = 1'b0;
    reg_rdata = '0;
    reg_error = 1'b0;

    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_reg_valid", reg_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    rst = 1'b0;

    // Stray target ready while idle
    reg_ready = 1'b1;
    reg_rdata = 32'hDEAD;
    tick();
    chk("stray_req_ready", req_ready, 0);
    chk("stray_reg_valid", reg_valid, 0);
    reg_ready = 1'b0;

    // Single read
    valid[0] = 1'b1;
    addr[0]  = 64'h100;
    tick();
    chk("rd_reg_valid", reg_valid, 1);
    chk("rd_reg_addr", reg_addr, 64'h100);
    chk("rd_reg_write", reg_write, 0);
    tick();
    chk("rd_wait_ready", req_ready, 0);
    reg_ready = 1'b1;
    reg_rdata = 32'hCAFE0001;
    tick();
    chk("rd_req_ready", req_ready, 3'b001);
    chk("rd_rsp_rdata", rsp_rdata, 32'hCAFE0001);
    chk("rd_rsp_error", rsp_error, 0);
    chk("rd_reg_valid_off", reg_valid, 0);
    chk("rd_model_rdata", e_rdata, 32'hCAFE0001);
    reg_ready = 1'b0;
    valid[0]  = 1'b0;
    tick();
    chk("rd_pulse_end", req_ready, 0);
    chk("rd_rdata_zero", rsp_rdata, 0);

    // Contention from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr[0] = 64'h1000; wdata[0] = 32'hA0;
    wstrb[0] = 4'hF;   write[0] = 1'b1;
    addr[1] = 64'h2000; wdata[1] = 32'hB1;
    wstrb[1] = 4'h3;   write[1] = 1'b0;
    valid = 3'b011;
    for (int t = 0; t < 4; t++) begin
      wait_valid();
      if (t == 0) begin
        chk("ct_first_addr", reg_addr, 64'h1000);
        chk("ct_first_write", reg_write, 1);
        chk("ct_first_wdata", reg_wdata, 32'hA0);
      end
      reg_ready = 1'b1;
      reg_rdata = 32'(t);
      tick();
      reg_ready = 1'b0;
      chk("ct_grant", req_ready, ct_exp[t]);
      chk("ct_rdata", rsp_rdata, 32'(t));
      if (t == 3) valid = '0;
      tick();
    end

    // Timeout with a silent target
    valid[2] = 1'b1;
    addr[2]  = 64'h30;
    tick();
    tn = 0;
    while (reg_valid && tn < 50) begin
      tn++;
      tick();
    end
    chk("to_busy_len", tn, TMO);
    chk("to_req_ready", req_ready, 3'b100);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    valid[2] = 1'b0;
    tick();

    // Target error on a write
    valid[1] = 1'b1;
    write[1] = 1'b1;
    addr[1]  = 64'h44;
    wdata[1] = 32'h55AA55AA;
    wstrb[1] = 4'b0011;
    tick();
    chk("we_reg_write", reg_write, 1);
    chk("we_reg_addr", reg_addr, 64'h44);
    chk("we_reg_wdata", reg_wdata, 32'h55AA55AA);
    chk("we_reg_wstrb", reg_wstrb, 4'b0011);
    reg_ready = 1'b1;
    reg_error = 1'b1;
    reg_rdata = 32'h12345678;
    tick();
    chk("we_req_ready", req_ready, 3'b010);
    chk("we_rsp_error", rsp_error, 1);
    chk("we_rsp_rdata", rsp_rdata, 32'h12345678);
    reg_ready = 1'b0;
    reg_error = 1'b0;
    valid = '0;
    tick();

    // Payload change and valid drop after grant
    valid[0] = 1'b1;
    write[0] = 1'b0;
    addr[0]  = 64'h10;
    tick();
    chk("pc_addr0", reg_addr, 64'h10);
    addr[0]  = 64'h20;
    wdata[0] = 32'hFF;
    valid[0] = 1'b0;
    tick();
    chk("pc_addr1", reg_addr, 64'h10);
    tick();
    chk("pc_addr2", reg_addr, 64'h10);
    chk("pc_valid", reg_valid, 1);
    reg_ready = 1'b1;
    reg_rdata = 32'h77;
    tick();
    chk("pc_req_ready", req_ready, 3'b001);
    chk("pc_rsp_rdata", rsp_rdata, 32'h77);
    reg_ready = 1'b0;
    tick();

    // Reset in the middle of a transfer
    addr[0]  = 64'h1000;
    addr[1]  = 64'h2000;
    valid[1] = 1'b1;
    tick();
    chk("rb_busy", reg_valid, 1);
    chk("rb_addr", reg_addr, 64'h2000);
    rst = 1'b1;
    tick();
    chk("rb_reg_valid", reg_valid, 0);
    chk("rb_req_ready", req_ready, 0);
    chk("rb_reg_addr", reg_addr, 0);
    chk("rb_rsp_error", rsp_error, 0);
    rst = 1'b0;
    valid[0] = 1'b1;
    tick();
    chk("rb_regrant_addr", reg_addr, 64'h1000);
    reg_ready = 1'b1;
    reg_rdata = 32'h99;
    tick();
    chk("rb_req_ready", req_ready, 3'b001);
    reg_ready = 1'b0;
    valid = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
